// File: rtl/alu_exec_unit_pkg.sv
// Shared encodings for the ALU execute unit.
// Holds the main-control alu_op classes, the R-type funct codes, and the
// 4-bit ALU control codes used between alu_control and the datapath.
package alu_exec_unit_pkg;

  localparam int DATA_W = 32;

  // Main-control ALU classes
  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_RTYPE = 2'b10;
  localparam logic [1:0] ALU_OP_RSVD  = 2'b11;

  // R-type funct field codes
  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;
  localparam logic [5:0] FUNCT_NOR = 6'b100111;
  localparam logic [5:0] FUNCT_SLL = 6'b000000;
  localparam logic [5:0] FUNCT_SRL = 6'b000010;

  // Decoded ALU operation codes
  typedef enum logic [3:0] {
    CTL_AND = 4'b0000,
    CTL_OR  = 4'b0001,
    CTL_ADD = 4'b0010,
    CTL_SUB = 4'b0110,
    CTL_SLT = 4'b0111,
    CTL_SLL = 4'b1000,
    CTL_SRL = 4'b1001,
    CTL_NOR = 4'b1100,
    CTL_INV = 4'b1111
  } alu_ctl_e;

endpackage

// File: rtl/alu_exec_unit_alu_control.sv
// ALU control decoder.
// Maps the main-control class (alu_op) and, for R-type, the funct field
// onto a 4-bit ALU operation code. Purely combinational.
// Ports:
//   alu_op  [1:0] in  : 00 add, 01 sub, 10 R-type, 11 reserved (treated as add)
//   funct   [5:0] in  : instruction bits [5:0]
//   alu_ctl [3:0] out : decoded ALU operation
module alu_control
  import alu_exec_unit_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [3:0] alu_ctl
);

  always_comb begin
    alu_ctl = CTL_ADD;
    unique case (alu_op)
      ALU_OP_ADD:   alu_ctl = CTL_ADD;
      ALU_OP_SUB:   alu_ctl = CTL_SUB;
      ALU_OP_RSVD:  alu_ctl = CTL_ADD;
      ALU_OP_RTYPE: begin
        case (funct)
          FUNCT_ADD: alu_ctl = CTL_ADD;
          FUNCT_SUB: alu_ctl = CTL_SUB;
          FUNCT_AND: alu_ctl = CTL_AND;
          FUNCT_OR:  alu_ctl = CTL_OR;
          FUNCT_SLT: alu_ctl = CTL_SLT;
          FUNCT_NOR: alu_ctl = CTL_NOR;
          FUNCT_SLL: alu_ctl = CTL_SLL;
          FUNCT_SRL: alu_ctl = CTL_SRL;
          default:   alu_ctl = CTL_INV;
        endcase
      end
      default: alu_ctl = CTL_ADD;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Single-cycle execute stage: ALU control decode, operand select, ALU,
// zero detect, next-PC adders and the PC register.
// Ports:
//   clk, reset         : clock and asynchronous active-high reset
//   alu_op, funct      : ALU class and R-type function field
//   shamt              : shift amount for sll/srl
//   rd1, rd2, imm      : operand A, register rt value, sign-extended immediate
//   alu_src, branch    : operand B select (1 = imm), branch instruction flag
//   alu_ctl            : decoded ALU operation
//   result, zero       : ALU result and result==0 flag
//   pc, pc_plus4       : current PC and PC+4
//   branch_target      : pc_plus4 + (imm << 2)
module alu_exec_unit
  import alu_exec_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  alu_op,
  input  logic [5:0]  funct,
  input  logic [4:0]  shamt,
  input  logic [31:0] rd1,
  input  logic [31:0] rd2,
  input  logic [31:0] imm,
  input  logic        alu_src,
  input  logic        branch,
  output logic [3:0]  alu_ctl,
  output logic [31:0] result,
  output logic        zero,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] branch_target
);

  logic [DATA_W-1:0]        op_b;
  logic signed [DATA_W-1:0] a_s;
  logic signed [DATA_W-1:0] b_s;
  logic [DATA_W-1:0]        imm_x4;

  alu_control u_alu_control (
    .alu_op  (alu_op),
    .funct   (funct),
    .alu_ctl (alu_ctl)
  );

  assign op_b = alu_src ? imm : rd2;
  assign a_s  = rd1;
  assign b_s  = op_b;

  always_comb begin
    result = '0;
    case (alu_ctl)
      CTL_AND: result = rd1 & op_b;
      CTL_OR:  result = rd1 | op_b;
      CTL_ADD: result = rd1 + op_b;
      CTL_SUB: result = rd1 - op_b;
      CTL_SLT: result = (a_s < b_s) ? 32'd1 : 32'd0;
      CTL_NOR: result = ~(rd1 | op_b);
      CTL_SLL: result = op_b << shamt;
      CTL_SRL: result = op_b >> shamt;
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

  // Shifting the full immediate drops imm[31:30] out of the 32-bit result.
  assign imm_x4        = imm << 2;
  assign pc_plus4      = pc + 32'd4;
  assign branch_target = pc_plus4 + imm_x4;

  // PC register stage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc <= RESET_PC;
    end else if (branch && zero) begin
      pc <= branch_target;
    end else begin
      pc <= pc_plus4;
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
module tb_alu_exec_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  alu_op;
  logic [5:0]  funct;
  logic [4:0]  shamt;
  logic [31:0] rd1, rd2, imm;
  logic        alu_src, branch;
  logic [3:0]  alu_ctl;
  logic [31:0] result, pc, pc_plus4, branch_target;
  logic        zero;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_pc = RST_PC;

  alu_exec_unit #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .reset(reset), .alu_op(alu_op), .funct(funct), .shamt(shamt),
    .rd1(rd1), .rd2(rd2), .imm(imm), .alu_src(alu_src), .branch(branch),
    .alu_ctl(alu_ctl), .result(result), .zero(zero), .pc(pc),
    .pc_plus4(pc_plus4), .branch_target(branch_target)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  function automatic logic [3:0] m_ctl(input logic [1:0] op, input logic [5:0] f);
    if (op == 2'b00 || op == 2'b11) return 4'b0010;
    if (op == 2'b01) return 4'b0110;
    case (f)
      6'd32: return 4'b0010;
      6'd34: return 4'b0110;
      6'd36: return 4'b0000;
      6'd37: return 4'b0001;
      6'd42: return 4'b0111;
      6'd39: return 4'b1100;
      6'd0:  return 4'b1000;
      6'd2:  return 4'b1001;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] m_res(input logic [1:0] op, input logic [5:0] f,
                                        input logic [4:0] sh, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (op != 2'b10) return (op == 2'b01) ? a - b : a + b;
    case (f)
      6'd32: return a + b;
      6'd34: return a - b;
      6'd36: return a & b;
      6'd37: return a | b;
      6'd42: return (sa < sb) ? 32'd1 : 32'd0;
      6'd39: return ~(a | b);
      6'd0:  return b << sh;
      6'd2:  return b >> sh;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] m_b();
    return alu_src ? imm : rd2;
  endfunction

  function automatic logic [31:0] m_target(input logic [31:0] p);
    return p + 32'd4 + 32'(imm * 4);
  endfunction

  // PC model: next pc from the model's own zero decision.
  always @(posedge reset) exp_pc = RST_PC;
  always @(posedge clk) begin
    if (!reset) begin
      if (branch && m_res(alu_op, funct, shamt, rd1, m_b()) == 32'd0)
        exp_pc = m_target(exp_pc);
      else
        exp_pc = exp_pc + 32'd4;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    logic [31:0] r;
    r = m_res(alu_op, funct, shamt, rd1, m_b());
    chk("mdl_ctl", {28'd0, alu_ctl}, {28'd0, m_ctl(alu_op, funct)});
    chk("mdl_result", result, r);
    chk("mdl_zero", {31'd0, zero}, {31'd0, (r == 32'd0)});
    chk("mdl_pc", pc, exp_pc);
    chk("mdl_pc4", pc_plus4, exp_pc + 32'd4);
    chk("mdl_target", branch_target, m_target(exp_pc));
  end

  task automatic edge_drive();
    @(posedge clk);
    #2;
  endtask

  task automatic rtype(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    alu_op = 2'b10; funct = f; rd1 = a; rd2 = b; alu_src = 1'b0;
    #1;
  endtask

  task automatic go_to_pc8();
    alu_op = 2'b00; funct = 6'd0; rd1 = 0; rd2 = 0; imm = 0; alu_src = 0; branch = 0;
    edge_drive();
    reset = 1'b1;
    #1;
    reset = 1'b0;
    edge_drive();
    edge_drive();
    chk("pc8_setup", pc, 32'd8);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    reset = 1'b1; alu_op = 2'b00; funct = 6'd0; shamt = 5'd0;
    rd1 = 0; rd2 = 0; imm = 0; alu_src = 1'b0; branch = 1'b0;
    #1;
    chk("reset_pc", pc, RST_PC);
    edge_drive();
    chk("reset_hold", pc, RST_PC);
    reset = 1'b0;
    #1;
    chk("release_no_update", pc, 32'd0);
    edge_drive(); chk("pc_1", pc, 32'd4);
    edge_drive(); chk("pc_2", pc, 32'd8);
    edge_drive(); chk("pc_3", pc, 32'd12);
    // Mid-cycle asynchronous reset
    #1; reset = 1'b1; #1;
    chk("async_reset", pc, 32'd0);
    edge_drive();
    chk("reset_hold2", pc, 32'd0);
    reset = 1'b0;

    // R-type
    rtype(6'b100000, 10, 20); chk("add", result, 32'd30);
    chk("add_ctl", {28'd0, alu_ctl}, 32'h2);
    rtype(6'b100010, 10, 20); chk("sub", result, 32'hFFFF_FFF6);
    rtype(6'b100100, 10, 20); chk("and", result, 32'd0);
    chk("and_zero", {31'd0, zero}, 32'd1);
    rtype(6'b100101, 10, 20); chk("or", result, 32'd30);
    rtype(6'b101010, 10, 20); chk("slt", result, 32'd1);
    rtype(6'b100010, 20, 20); chk("sub_eq", result, 32'd0);
    chk("sub_eq_zero", {31'd0, zero}, 32'd1);
    edge_drive();

    // Shifts and nor
    shamt = 5'd4;
    rtype(6'b000000, 0, 32'h8000_0001); chk("sll", result, 32'h0000_0010);
    chk("sll_ctl", {28'd0, alu_ctl}, 32'h8);
    rtype(6'b000010, 0, 32'h8000_0001); chk("srl", result, 32'h0800_0000);
    shamt = 5'd0; #1; chk("srl_sh0", result, 32'h8000_0001);
    shamt = 5'd31;
    rtype(6'b000000, 0, 32'h0000_0003); chk("sll_sh31", result, 32'h8000_0000);
    rtype(6'b100111, 0, 0); chk("nor", result, 32'hFFFF_FFFF);
    chk("nor_zero", {31'd0, zero}, 32'd0);
    shamt = 5'd0;
    edge_drive();

    // I-type add with negative immediate, reserved alu_op
    alu_op = 2'b00; alu_src = 1'b1; rd1 = 30; imm = 32'hFFFF_FFFC; rd2 = 32'd1000; #1;
    chk("itype", result, 32'd26);
    chk("itype_ctl", {28'd0, alu_ctl}, 32'h2);
    alu_op = 2'b11; #1;
    chk("rsvd_ctl", {28'd0, alu_ctl}, 32'h2);
    chk("rsvd_res", result, 32'd26);
    alu_op = 2'b01; rd1 = 32'd0; imm = 32'd1; #1;
    chk("sub_wrap", result, 32'hFFFF_FFFF);
    alu_src = 1'b0; imm = 0;
    edge_drive();

    // Unknown funct, signed slt
    rtype(6'b111111, 5, 7);
    chk("inv_ctl", {28'd0, alu_ctl}, 32'hF);
    chk("inv_res", result, 32'd0);
    chk("inv_zero", {31'd0, zero}, 32'd1);
    rtype(6'b101010, 32'hFFFF_FFFF, 1); chk("slt_signed", result, 32'd1);
    rtype(6'b101010, 1, 32'hFFFF_FFFF); chk("slt_signed_rev", result, 32'd0);
    edge_drive();

    // Branch taken
    go_to_pc8();
    alu_op = 2'b01; rd1 = 50; rd2 = 50; branch = 1'b1; imm = 32'd3; alu_src = 1'b0; #1;
    chk("br_target", branch_target, 32'd24);
    edge_drive();
    chk("br_taken", pc, 32'd24);
    // Branch not taken
    go_to_pc8();
    alu_op = 2'b01; rd1 = 50; rd2 = 40; branch = 1'b1; imm = 32'd3; alu_src = 1'b0;
    edge_drive();
    chk("br_not_taken", pc, 32'd12);
    // Target wrap with imm[31:30] discarded: imm = 0xC000_0001 -> +4
    imm = 32'hC000_0001; #1;
    chk("br_imm_discard", branch_target, 32'd20);
    branch = 1'b0; imm = 0;
    edge_drive();
    edge_drive();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, value loaded into pc on reset.
REQ-002 clk  input  1  single clock; pc register updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 alu_op  input  2  main-control ALU class: 00 add, 01 sub, 10 R-type (use funct), 11 reserved.
REQ-005 funct  input  6  instruction bits [5:0].
REQ-006 shamt  input  5  instruction bits [10:6], shift amount.
REQ-007 rd1  input  32  operand A (register rs).
REQ-008 rd2  input  32  register rt value.
REQ-009 imm  input  32  sign-extended immediate.
REQ-010 alu_src  input  1  operand B select: 0 rd2, 1 imm.
REQ-011 branch  input  1  branch instruction flag.
REQ-012 alu_ctl  output  4  decoded ALU operation code.
REQ-013 result  output  32  ALU result.
REQ-014 zero  output  1  high when result == 0.
REQ-015 pc  output  32  current program counter.
REQ-016 pc_plus4  output  32  pc + 4.
REQ-017 branch_target  output  32  pc_plus4 + (imm << 2).

Function
REQ-018 ALU control SHALL be combinational: alu_op 00 -> 0010; 01 -> 0110; 11 -> 0010; 10 decodes funct: 100000 -> 0010 (add), 100010 -> 0110 (sub), 100100 -> 0000 (and), 100101 -> 0001 (or), 101010 -> 0111 (slt), 100111 -> 1100 (nor), 000000 -> 1000 (sll), 000010 -> 1001 (srl), any other funct -> 1111.
REQ-019 Operand B SHALL be imm when alu_src=1, else rd2.
REQ-020 ALU SHALL be combinational: 0000 A&B; 0001 A|B; 0010 A+B; 0110 A-B; 0111 1 if signed A<B else 0; 1100 ~(A|B); 1000 B<<shamt (logical); 1001 B>>shamt (logical, zero fill); any other code -> 0.
REQ-021 Add and subtract SHALL wrap modulo 2^32; no overflow flag or trap.
REQ-022 slt SHALL compare two's-complement; result is 32-bit 0 or 1.
REQ-023 Shifts SHALL use shamt only (0..31); shamt 0 passes B unchanged.
REQ-024 zero SHALL be high exactly when result == 0, for every operation.
REQ-025 pc_plus4 and branch_target SHALL be combinational, 32-bit, wrapping; imm<<2 discards imm[31:30].
REQ-026 On each rising clk with reset low, pc SHALL load branch_target if (branch & zero), else pc_plus4.
REQ-027 alu_src, alu_op and funct changes SHALL affect outputs within the same cycle (no latency except pc).

Reset
REQ-028 reset high SHALL force pc to RESET_PC immediately, independent of clk.
REQ-029 While reset is high, pc SHALL hold RESET_PC; combinational outputs follow inputs and pc.
REQ-030 First update after reset release SHALL occur on the next rising clk edge.

Structure
REQ-031 A shared package SHALL hold the alu_op encodings, funct codes and 4-bit ALU control codes as named constants.
REQ-032 The block SHALL instantiate one alu_control sub-module (alu_op, funct -> alu_ctl); ALU, adders and pc register are implemented inline.

Verification
REQ-033 Reset: assert reset mid-cycle -> pc = 0 at once; release, 3 rising edges with branch=0 -> pc = 4, 8, 12.
REQ-034 R-type: rd1=10, rd2=20, alu_op=10, funct add/sub/and/or/slt -> result 30, 0xFFFFFFF6, 0, 30, 1; sub with rd1=rd2=20 -> result 0, zero=1.
REQ-035 Shifts: rd2=0x80000001, shamt=4; sll -> 0x00000010, srl -> 0x08000000; nor with rd1=0, rd2=0 -> 0xFFFFFFFF.
REQ-036 I-type: alu_op=00, alu_src=1, rd1=30, imm=0xFFFFFFFC -> result 26, alu_ctl=0010.
REQ-037 Branch: pc=8, alu_op=01, rd1=rd2=50, branch=1, imm=3 -> branch_target 24, pc=24 after edge; rd2=40 -> pc=12.
REQ-038 Unknown funct 111111 with alu_op=10 -> alu_ctl=1111, result 0, zero=1; signed slt rd1=0xFFFFFFFF, rd2=1 -> result 1.
